// File: rtl/bus_pkg.sv
// Shared bus widths for the valid/ready interconnect.
package bus_pkg;
   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/bus_mem_slave_if.sv
// Valid/ready request/response bundle between an initiator and bus_mem_slave.
interface bus_mem_slave_if;
   import bus_pkg::*;

   logic                  valid;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  we;
   logic                  ready;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  err;
   logic                  busy;
   logic                  proto_err;

   modport master (
      output valid, addr, wdata, we,
      input  ready, rdata, err, busy, proto_err
   );

   modport slave (
      input  valid, addr, wdata, we,
      output ready, rdata, err, busy, proto_err
   );
endinterface

// File: rtl/bus_mem_slave.sv
// Word-addressed memory responder with programmable wait states, registered
// responses, out-of-range error flagging and sticky abort detection.
//
// state  | meaning
// S_IDLE | waiting for valid; accepting edge latches the request
// S_WAIT | counting wait states; valid must stay high
// S_RESP | one-cycle ready strobe with rdata/err
module bus_mem_slave
   import bus_pkg::*;
#(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic            clk_i,
   input logic            rst_ni,
   bus_mem_slave_if.slave bus
);

   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam int IW = (MEM_DEPTH < 2) ? 1 : $clog2(MEM_DEPTH);
   localparam logic [CW-1:0]       CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
   localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic                  in_range_q;
   logic                  ready_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  proto_err_q;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept, to_resp, abort;
   logic                  in_range_now;
   logic [IW-1:0]         sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  sel_we, sel_in_range;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic                  err_d;

   // Full-width compare so high address bits can never alias into the array.
   assign in_range_now = {1'b0, bus.addr} < DEPTH_W;

   // With zero wait states the response is built at the acceptance edge,
   // before the latched copies exist, so the live bus is used in IDLE.
   always_comb begin
      sel_addr     = addr_q;
      sel_wdata    = wdata_q;
      sel_we       = we_q;
      sel_in_range = in_range_q;
      if (state_q == S_IDLE) begin
         sel_addr     = bus.addr[IW-1:0];
         sel_wdata    = bus.wdata;
         sel_we       = bus.we;
         sel_in_range = in_range_now;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      to_resp = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
                  to_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!bus.valid) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               abort   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_RESP;
               to_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_we  = to_resp & sel_we & sel_in_range & rst_ni;
      rdata_d = '0;
      err_d   = to_resp & ~sel_in_range;
      if (to_resp && !sel_we && sel_in_range) rdata_d = mem[sel_addr];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         in_range_q  <= 1'b0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= to_resp;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            addr_q     <= bus.addr[IW-1:0];
            wdata_q    <= bus.wdata;
            we_q       <= bus.we;
            in_range_q <= in_range_now;
         end
         if (abort) proto_err_q <= 1'b1;
      end
   end

   // Storage is deliberately unreset; reset only gates the write enable.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[sel_addr] <= sel_wdata;
   end

   assign bus.ready     = ready_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed scoreboard bench for bus_mem_slave with 2 and 0 wait states.
module tb_bus_mem_slave;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   rdy_cyc = 0;
   int   prev_cyc;

   exp_t        sb[$];
   logic [31:0] m2 [256];
   logic [31:0] m0 [256];

   bus_mem_slave_if b2 ();
   bus_mem_slave_if b0 ();

   bus_mem_slave #(.MEM_DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (b2)
   );

   bus_mem_slave #(.MEM_DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (b0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic set_bus(input bit sel, input logic v, input logic we,
                          input logic [15:0] a, input logic [31:0] d);
      if (sel) begin
         b2.valid = v; b2.we = we; b2.addr = a; b2.wdata = d;
      end else begin
         b0.valid = v; b0.we = we; b0.addr = a; b0.wdata = d;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? b2.ready : b0.ready;
   endfunction

   function automatic logic bsy(input bit sel);
      return sel ? b2.busy : b0.busy;
   endfunction

   // Issue one request; optionally alter addr/wdata after acceptance.
   task automatic req(input bit sel, input logic we, input logic [15:0] a,
                      input logic [31:0] d, input bit chg,
                      input logic [15:0] ca, input logic [31:0] cd);
      exp_t        e;
      exp_t        got_e;
      int          n;
      bit          got;
      int          lat;
      logic [7:0]  idx;
      bit          inr;
      lat = sel ? 3 : 1;
      idx = a[7:0];
      inr = (a < 16'd256);
      if (!inr)    e = '{rdata: 32'h0, err: 1'b1};
      else if (we) e = '{rdata: 32'h0, err: 1'b0};
      else         e = '{rdata: (sel ? m2[idx] : m0[idx]), err: 1'b0};
      sb.push_back(e);
      set_bus(sel, 1'b1, we, a, d);
      n = 0;
      got = 0;
      while (!got && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (rdy(sel)) got = 1;
         else begin
            check("busy_wait", {31'b0, bsy(sel)}, 32'd1);
            if (chg && n == 1) set_bus(sel, 1'b1, we, ca, cd);
         end
      end
      check("latency", n, lat);
      got_e = sb.pop_front();
      if (got) begin
         rdy_cyc = cyc;
         check("rdata", (sel ? b2.rdata : b0.rdata), got_e.rdata);
         check("err", {31'b0, (sel ? b2.err : b0.err)}, {31'b0, got_e.err});
         check("busy_resp", {31'b0, bsy(sel)}, 32'd1);
         if (we && inr) begin
            if (sel) m2[idx] = d;
            else     m0[idx] = d;
         end
      end
      set_bus(sel, 1'b0, 1'b0, 16'h0, 32'h0);
      @(posedge clk);
      #1;
      check("ready_drop", {31'b0, rdy(sel)}, 32'd0);
      check("busy_idle", {31'b0, bsy(sel)}, 32'd0);
   endtask

   initial begin
      set_bus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      set_bus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", {31'b0, b2.ready}, 32'd0);
      check("rst_rdata", b2.rdata, 32'd0);
      check("rst_err", {31'b0, b2.err}, 32'd0);
      check("rst_busy", {31'b0, b2.busy}, 32'd0);
      check("rst_proto", {31'b0, b2.proto_err}, 32'd0);
      check("rst_ready0", {31'b0, b0.ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // basic write then read with two wait states
      req(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 16'h0, 32'h0);
      check("t1_data", m2[8'h10], 32'hDEADBEEF);

      // out-of-range accesses must not alias into low words
      req(1'b1, 1'b1, 16'h0000, 32'hCAFE0000, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b1, 16'h00FF, 32'h0F0F0F0F, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b0, 16'h0100, 32'h0, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b1, 16'hFFFF, 32'h12121212, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b1, 16'h0100, 32'h34343434, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b0, 16'h0000, 32'h0, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b0, 16'h00FF, 32'h0, 1'b0, 16'h0, 32'h0);

      // zero wait states: preload then back-to-back reads every second cycle
      for (int i = 0; i < 4; i++)
         req(1'b0, 1'b1, 16'(i), 32'h11 * (i + 1), 1'b0, 16'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         prev_cyc = rdy_cyc;
         req(1'b0, 1'b0, 16'(i), 32'h0, 1'b0, 16'h0, 32'h0);
         if (i > 0) check("b2b_spacing", rdy_cyc - prev_cyc, 32'd2);
      end

      // abort during WAIT
      req(1'b1, 1'b1, 16'h0020, 32'h12345678, 1'b0, 16'h0, 32'h0);
      set_bus(1'b1, 1'b1, 1'b1, 16'h0020, 32'h00000005);
      @(posedge clk);
      #1;
      check("abort_busy", {31'b0, b2.busy}, 32'd1);
      set_bus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      @(posedge clk);
      #1;
      check("abort_proto", {31'b0, b2.proto_err}, 32'd1);
      check("abort_idle", {31'b0, b2.busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_ready", {31'b0, b2.ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      req(1'b1, 1'b0, 16'h0020, 32'h0, 1'b0, 16'h0, 32'h0);
      check("proto_sticky", {31'b0, b2.proto_err}, 32'd1);
      check("proto_other", {31'b0, b0.proto_err}, 32'd0);

      // reset during WAIT drops the write
      req(1'b1, 1'b1, 16'h0030, 32'h000000A5, 1'b0, 16'h0, 32'h0);
      set_bus(1'b1, 1'b1, 1'b1, 16'h0030, 32'h000000FF);
      @(posedge clk);
      #1;
      check("pre_rst_busy", {31'b0, b2.busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, b2.busy}, 32'd0);
      check("arst_proto", {31'b0, b2.proto_err}, 32'd0);
      check("arst_ready", {31'b0, b2.ready}, 32'd0);
      check("arst_rdata", b2.rdata, 32'd0);
      set_bus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req(1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 16'h0, 32'h0);
      check("rst_keep", m2[8'h30], 32'h000000A5);

      // bus changes after acceptance are ignored
      req(1'b1, 1'b1, 16'h0040, 32'h00000055, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b1, 16'h0041, 32'h00000077, 1'b1, 16'h0040, 32'h00000099);
      req(1'b1, 1'b0, 16'h0041, 32'h0, 1'b0, 16'h0, 32'h0);
      req(1'b1, 1'b0, 16'h0040, 32'h0, 1'b0, 16'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
